// File: rtl/if_stage_unit.sv
// Instruction-fetch stage: owns the PC, presents it to the combinational
// instruction memory, and captures {instruction, PC+step} into IF/ID.
// Branch redirect outranks freeze for the PC. Flush outranks freeze for IF/ID.
// Saturating counters record how many instructions were fetched and how many cycles were stalled.
module if_stage_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             branch_taken,
  input  logic [31:0]      branch_addr,
  input  logic             flush,
  input  logic [31:0]      inst_in,
  output logic [31:0]      pc_out,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_inst,
  output logic             id_valid,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      id_pc_q, id_pc_d;
  logic [31:0]      id_inst_q, id_inst_d;
  logic             id_valid_q, id_valid_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [31:0] pc_next_seq;
  logic        load_ifid;
  logic        stall_evt;

  // Next PC: the redirect target, or the held PC, or the sequential PC.
  always_comb begin
    pc_next_seq = pc_q + PC_STEP;
    pc_d        = pc_q;
    if (branch_taken) begin
      pc_d = {branch_addr[31:2], 2'b00};
    end else if (!freeze) begin
      pc_d = pc_next_seq;
    end
  end

  // IF/ID register: flush clears it, freeze holds it, and otherwise it captures the fetched word.
  always_comb begin
    load_ifid  = !flush && !freeze;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (flush) begin
      id_pc_d    = 32'd0;
      id_inst_d  = 32'd0;
      id_valid_d = 1'b0;
    end else if (!freeze) begin
      id_pc_d    = pc_next_seq;
      id_inst_d  = inst_in;
      id_valid_d = 1'b1;
    end
  end

  // Performance counters, saturating at all-ones.
  always_comb begin
    stall_evt   = freeze && !branch_taken && !flush;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (load_ifid && !(&fetch_cnt_q)) begin
      fetch_cnt_d = fetch_cnt_q + CNT_ONE;
    end
    if (stall_evt && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  // State registers with synchronous reset overriding all other inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      id_pc_q     <= 32'd0;
      id_inst_q   <= 32'd0;
      id_valid_q  <= 1'b0;
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
      id_valid_q  <= id_valid_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_out    = pc_q;
  assign id_pc     = id_pc_q;
  assign id_inst   = id_inst_q;
  assign id_valid  = id_valid_q;
  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule
